// File: rtl/partition_error_sweeper.sv
// Exhaustive input sweeper and error accumulator for a partitioned combinational block.
// Define PARTITION_SWEEP_WCE_EN to add the wce_pi output (first worst-case pattern).
module partition_error_sweeper #(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic [IN_W-1:0]                     pi,
    input  logic [OUT_W-1:0]                    exact_po,
    input  logic [OUT_W-1:0]                    approx_po,
    output logic                                busy,
    output logic                                done,
    output logic [IN_W:0]                       err_cnt,
    output logic [IN_W+$clog2(OUT_W+1)-1:0]     ham_sum,
    output logic [OUT_W-1:0]                    max_abs_err
`ifdef PARTITION_SWEEP_WCE_EN
    ,
    output logic [IN_W-1:0]                     wce_pi
`endif
);

    localparam int unsigned HAM_W       = IN_W + $clog2(OUT_W + 1);
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FIN    = 2'd3;

    logic [1:0]       state;
    logic [3:0]       settle_cnt;
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] abs_err;
    logic [HAM_W-1:0] pop;

    always_comb begin
        diff = exact_po ^ approx_po;
        pop  = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            pop = pop + HAM_W'(diff[i]);
        end
        // Compare-and-subtract keeps the magnitude unsigned without wrap.
        abs_err = (exact_po >= approx_po) ? (exact_po - approx_po) : (approx_po - exact_po);
    end

    assign busy = (state == ST_APPLY) || (state == ST_SAMPLE);
    assign done = (state == ST_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            pi          <= '0;
            err_cnt     <= '0;
            ham_sum     <= '0;
            max_abs_err <= '0;
`ifdef PARTITION_SWEEP_WCE_EN
            wce_pi      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_APPLY;
                        settle_cnt  <= SETTLE_INIT;
                        pi          <= '0;
                        err_cnt     <= '0;
                        ham_sum     <= '0;
                        max_abs_err <= '0;
`ifdef PARTITION_SWEEP_WCE_EN
                        wce_pi      <= '0;
`endif
                    end
                end
                ST_APPLY: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (diff != '0) begin
                        err_cnt <= err_cnt + (IN_W + 1)'(1);
                    end
                    ham_sum <= ham_sum + pop;
                    if (abs_err > max_abs_err) begin
                        max_abs_err <= abs_err;
`ifdef PARTITION_SWEEP_WCE_EN
                        wce_pi      <= pi;
`endif
                    end
                    if (&pi) begin
                        state <= ST_FIN;
                    end else begin
                        pi         <= pi + IN_W'(1);
                        settle_cnt <= SETTLE_INIT;
                        state      <= ST_APPLY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
